timer_irq_src: RTL

Memory-mapped countdown timer on the CPU bridge. It is the interrupt source that drives one CP0 hardware-interrupt line (`HWInt[10]`). Software programs PRESET and CTRL through store instructions. The block counts down and raises `IRQ`, which CP0 latches into Cause.IP and gates with SR.IM/IE/EXL. Software reads COUNT and CTRL back via load instructions.

---
 rtl/timer_irq_src.sv | 115 +++++++++++
 1 files changed

// File: rtl/timer_irq_src.sv
// Memory-mapped countdown timer that raises a level interrupt toward CP0 HWInt.
// CTRL = {IM, Mode[1:0], Enable}; Mode 01 auto-reloads, other modes are one-shot.
module timer_irq_src #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Addr,
    input  logic             We,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Dout,
    output logic             IRQ
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_CNT     = 2'd2;
    localparam logic [1:0] S_INT     = 2'd3;
    localparam logic [1:0] MODE_AUTO = 2'b01;

    logic [1:0]       state_q, state_d;
    logic             en_q, en_d;
    logic             im_q, im_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] preset_q, preset_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             irq_q, irq_d;
    logic             ctrl_wr_s;
    logic             preset_wr_s;
    logic             auto_s;

    assign ctrl_wr_s   = We && (Addr == 2'd0);
    assign preset_wr_s = We && (Addr == 2'd1);
    assign auto_s      = (mode_q == MODE_AUTO);

    // Next-state, register-write and interrupt decode
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        preset_d = preset_wr_s ? Din : preset_q;
        im_d     = ctrl_wr_s ? Din[3] : im_q;
        mode_d   = ctrl_wr_s ? Din[2:1] : mode_q;
        en_d     = ctrl_wr_s ? Din[0] : en_q;
        case (state_q)
            S_IDLE: begin
                state_d = en_q ? S_LOAD : S_IDLE;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q == {WIDTH{1'b0}}) begin
                    state_d = S_INT;
                    // one-shot entry clears Enable even over a same-edge CTRL write
                    en_d    = en_d & auto_s;
                end else begin
                    count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            S_INT: begin
                if (auto_s) begin
                    state_d = S_LOAD;
                end else if (ctrl_wr_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_INT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered copy of IM & (state == INT): same cycle timing as a decode of the flops
        irq_d = im_d & (state_d == S_INT);
    end

    // State and register flops with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            im_q     <= 1'b0;
            mode_q   <= 2'b00;
            preset_q <= {WIDTH{1'b0}};
            count_q  <= {WIDTH{1'b0}};
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            im_q     <= im_d;
            mode_q   <= mode_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Read mux
    always_comb begin
        Dout = {WIDTH{1'b0}};
        case (Addr)
            2'd0:    Dout = {{(WIDTH-4){1'b0}}, im_q, mode_q, en_q};
            2'd1:    Dout = preset_q;
            2'd2:    Dout = count_q;
            2'd3:    Dout = {WIDTH{1'b0}};
            default: Dout = {WIDTH{1'b0}};
        endcase
    end

    assign IRQ = irq_q;

endmodule
